// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: each channel emits a divided
// waveform plus a one-cycle tick, with divisor updates deferred to a wrap.
module clk_div_multi #(
  parameter int NUM_CH      = 3,
  parameter int CNT_W       = 17,
  parameter int DEFAULT_DIV = 100000
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              div_wr,
  input  logic [2:0]        div_sel,
  input  logic [CNT_W-1:0]  div_val,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] div_pending
);

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0]  cnt_q  [NUM_CH];
  logic [CNT_W-1:0]  cnt_d  [NUM_CH];
  logic [CNT_W-1:0]  act_q  [NUM_CH];
  logic [CNT_W-1:0]  act_d  [NUM_CH];
  logic [CNT_W-1:0]  pend_q [NUM_CH];
  logic [CNT_W-1:0]  pend_d [NUM_CH];
  logic [NUM_CH-1:0] pv_q, pv_d;
  logic [NUM_CH-1:0] clk_q, clk_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic              wr_ok;

  assign wr_ok = div_wr && (32'(div_sel) < NUM_CH) && (div_val >= CNT_W'(2));

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      cnt_d[i]  = cnt_q[i];
      act_d[i]  = act_q[i];
      pend_d[i] = pend_q[i];
      pv_d[i]   = pv_q[i];
      tick_d[i] = 1'b0;
      if (en[i]) begin
        if (cnt_q[i] == act_q[i] - ONE) begin
          cnt_d[i]  = '0;
          tick_d[i] = 1'b1;
          if (pv_q[i]) begin
            act_d[i] = pend_q[i];
            pv_d[i]  = 1'b0;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + ONE;
        end
      end
      // A write landing on the wrap edge is captured after the old pending value is consumed.
      if (wr_ok && (div_sel == 3'(i))) begin
        pend_d[i] = div_val;
        pv_d[i]   = 1'b1;
      end
      clk_d[i] = (cnt_d[i] < (act_d[i] >> 1));
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all channels update from the same old values.
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]  <= DEF_DIV - ONE;
        act_q[i]  <= DEF_DIV;
        pend_q[i] <= DEF_DIV;
      end
      pv_q   <= '0;
      clk_q  <= '0;
      tick_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]  <= cnt_d[i];
        act_q[i]  <= act_d[i];
        pend_q[i] <= pend_d[i];
      end
      pv_q   <= pv_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign clk_out     = clk_q;
  assign tick        = tick_q;
  assign div_pending = pv_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: a period-level model predicts outputs,
// a monitor compares them one cycle after each edge.
module tb_clk_div_multi;

  localparam int N   = 3;
  localparam int W   = 17;
  localparam int DEF = 4;

  logic          clk_in = 1'b0;
  logic          rst_n  = 1'b0;
  logic [N-1:0]  en     = '0;
  logic          div_wr = 1'b0;
  logic [2:0]    div_sel = '0;
  logic [W-1:0]  div_val = '0;
  logic [N-1:0]  clk_out, tick, div_pending;

  clk_div_multi #(.NUM_CH(N), .CNT_W(W), .DEFAULT_DIV(DEF)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .en(en), .div_wr(div_wr),
    .div_sel(div_sel), .div_val(div_val), .clk_out(clk_out),
    .tick(tick), .div_pending(div_pending)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [N-1:0] clk;
    logic [N-1:0] tk;
    logic [N-1:0] pend;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Model: each channel is "not yet started" after reset, otherwise sits at
  // some elapsed cycle count inside a period of known length.
  bit   m_started [N];
  int   m_phase   [N];
  int   m_period  [N];
  int   m_pend    [N];
  bit   m_pv      [N];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_started[i] = 0; m_phase[i] = 0; m_period[i] = DEF; m_pend[i] = DEF; m_pv[i] = 0;
    end
  endtask

  function automatic exp_t model_step(input logic [N-1:0] e, input logic w,
                                      input int s, input int v);
    exp_t r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (e[i]) begin
        if (!m_started[i] || (m_phase[i] + 1 >= m_period[i])) begin
          if (m_pv[i]) begin
            m_period[i] = m_pend[i];
            m_pv[i]     = 0;
          end
          m_phase[i]   = 0;
          m_started[i] = 1;
          r.tk[i]      = 1'b1;
        end else begin
          m_phase[i]++;
        end
      end
      if (w && s == i && v >= 2) begin
        m_pend[i] = v;
        m_pv[i]   = 1;
      end
      r.clk[i]  = m_started[i] && (m_phase[i] < m_period[i] / 2);
      r.pend[i] = m_pv[i];
    end
    return r;
  endfunction

  task automatic check_reset_outputs();
    check("rst_clk_out", int'(clk_out), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_div_pending", int'(div_pending), 0);
  endtask

  // One clock cycle of stimulus; optional asynchronous reset pulse between edges.
  task automatic step(input logic [N-1:0] e, input logic w, input logic [2:0] s,
                      input int v, input bit do_rst = 0);
    @(negedge clk_in);
    if (do_rst) begin
      rst_n = 1'b0;
      #1;
      check_reset_outputs();
      model_reset();
      #1;
      rst_n = 1'b1;
    end
    en      = e;
    div_wr  = w;
    div_sel = s;
    div_val = W'(v);
    q.push_back(model_step(e, w, int'(s), v));
  endtask

  always @(posedge clk_in) begin
    #1;
    if (rst_n && q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      check("clk_out", int'(clk_out), int'(x.clk));
      check("tick", int'(tick), int'(x.tk));
      check("div_pending", int'(div_pending), int'(x.pend));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    #3;
    check_reset_outputs();
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1;

    // Default divisor on all channels.
    repeat (12) step(3'b111, 0, 0, 0);
    // Odd divisor written to a disabled channel, then enabled.
    step(3'b101, 1, 3'd1, 5);
    repeat (3) step(3'b101, 0, 0, 0);
    repeat (15) step(3'b111, 0, 0, 0);
    // Mid-period update, then a second write colliding with the wrap.
    step(3'b111, 1, 3'd0, 6);
    repeat (5) step(3'b111, 0, 0, 0);
    step(3'b111, 1, 3'd0, 6);
    repeat (2) step(3'b111, 0, 0, 0);
    step(3'b111, 1, 3'd0, 8);
    repeat (20) step(3'b111, 0, 0, 0);
    // Illegal writes must be ignored.
    step(3'b111, 1, 3'd2, 0);
    step(3'b111, 1, 3'd2, 1);
    step(3'b111, 1, 3'd3, 7);
    step(3'b111, 1, 3'd7, 9);
    repeat (10) step(3'b111, 0, 0, 0);
    // Channel 2 gated for 7 cycles mid-period.
    repeat (7) step(3'b011, 0, 0, 0);
    repeat (12) step(3'b111, 0, 0, 0);
    // Asynchronous reset in the middle of a period.
    step(3'b111, 0, 0, 0, 1);
    repeat (10) step(3'b111, 0, 0, 0);

    for (int k = 0; k < 4000; k++) begin
      logic [N-1:0] e;
      logic         w;
      logic [2:0]   s;
      int           v;
      bit           r;
      e = ($urandom_range(0, 9) == 0) ? N'($urandom) : '1;
      w = ($urandom_range(0, 7) == 0);
      s = 3'($urandom_range(0, 4));
      v = $urandom_range(0, 12);
      r = ($urandom_range(0, 499) == 0);
      step(e, w, s, v, r);
    end

    @(negedge clk_in);
    en     = '0;
    div_wr = 1'b0;
    repeat (2) @(negedge clk_in);
    check("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Parametrised, multi-channel programmable clock divider and tick generator; successor to the fixed divide-by-four block.
- Derives NUM_CH independent slow strobes from the board clock, e.g. 1 kHz display scan, stopwatch/game-timer ticks and blink rates.
- Each channel produces a near-50%-duty divided waveform plus a one-cycle tick.
- Divisors are reprogrammable at runtime with glitch-free, period-boundary update.

Parameters:
- NUM_CH, 3, number of independent divider channels (1..8).
- CNT_W, 17, width of divisor and counter per channel.
- DEFAULT_DIV, 100000, reset divisor for every channel (100 MHz -> 1 kHz); must be >= 2 and < 2^CNT_W.

Ports:
- clk_in  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  NUM_CH  per-channel count enable.
- div_wr  input  1  divisor write strobe, one cycle per write.
- div_sel  input  3  target channel for div_wr.
- div_val  input  CNT_W  new divisor D.
- clk_out  output  NUM_CH  divided waveforms, registered.
- tick  output  NUM_CH  one-cycle pulse per divided period, registered.
- div_pending  output  NUM_CH  written divisor not yet applied.

Behaviour:
- Per-channel state: cnt[CNT_W], act_div[CNT_W], pend_div[CNT_W], pend_valid.
- Reset (async, any time, including mid-period or mid-write):
  - act_div = DEFAULT_DIV, cnt = DEFAULT_DIV-1 (pre-wrap).
  - pend_valid = 0, clk_out = 0, tick = 0, div_pending = 0.
- Counting, per channel i, with en[i]=1 each edge:
  - if cnt == act_div-1: cnt <= 0 (the "wrap").
  - otherwise: cnt <= cnt+1.
  - Output period is exactly act_div cycles.
- en[i]=0: cnt, act_div and clk_out[i] hold; tick[i]=0. Re-enabling resumes mid-period with no extra tick.
- clk_out[i] is flop-driven and always equals (cnt < act_div>>1), evaluated on the registered cnt/act_div.
  - Even D: exact 50% duty. Odd D: high floor(D/2), low ceil(D/2).
  - Since reset cnt = D-1, clk_out stays 0 until the first enabled edge.
- tick[i] = 1 for exactly the one cycle in which cnt == 0 following a wrap. It coincides with the rising edge of clk_out[i]. Never high while en[i]=0.
- Latency: the first enabled edge after reset performs a wrap, so tick and clk_out rise at the end of that cycle.
- Divisor write, on the div_wr=1 edge:
  - If div_sel < NUM_CH and div_val >= 2: pend_div[sel] <= div_val, pend_valid[sel] <= 1.
  - Otherwise: ignored, no state change.
- Apply point: on a wrap with pend_valid=1, act_div <= pend_div and pend_valid <= 0. The new period starts at cnt=0 with the new D. No truncated or stretched period is ever emitted.
- Pending state while disabled: a channel held disabled keeps its write pending until its next wrap.
- A second write to the same channel before the wrap overwrites pend_div (last write wins).
- Simultaneous write and wrap on one channel:
  - the wrap applies the previously pending value (if any);
  - the new write is captured as pending and applies at the following wrap.
- div_pending[i] = pend_valid[i].
- Channels are fully independent; one write affects only its selected channel.

Test Plan:
- Reset and count: DEFAULT_DIV=4, en=all-ones after reset -> each channel: tick at cycles 1,5,9,...; clk_out 1,1,0,0 repeating, phase-aligned with tick.
- Odd divisor: write D=5 to ch1 while ch1 is disabled, then enable -> div_pending[1]=1 until the first wrap; then clk_out[1] high 2, low 3, tick every 5 cycles; ch0 unaffected.
- Mid-period update: ch0 running D=4; at cnt=1, write D=6 -> current period completes in 4 cycles, next period is 6; div_pending[0] clears on the wrap edge.
- Write collides with wrap: at cnt=D-1 write D=8 while D=6 is already pending -> next period 6, the one after 8.
- Illegal writes: div_val=0, div_val=1, div_sel=NUM_CH -> no change to any act_div, pend_valid or outputs.
- Enable gating and reset mid-operation:
  - Drop en[2] for 7 cycles mid-period -> cnt and clk_out hold, no tick, period resumes exactly.
  - Assert rst_n=0 between edges -> outputs clear immediately; counting restarts per reset values.
